// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: RISC-V byte/half/word loads and stores onto a word-wide,
// one-cycle-latency data memory; sub-word stores run as read-modify-write.
module lsu_mem_ctrl #(
    parameter int MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, RD, USE, WR, DONE} state_t;

    state_t      state;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic [31:0] merged;

    logic        illegal, misal, oor;
    logic [1:0]  code;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_val;
    logic [31:0] rmw_mask;
    logic [31:0] rmw_data;

    // Request checks, in priority order: illegal > misaligned > out of range.
    always_comb begin
        illegal = we ? (funct3 > 3'd2)
                     : (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7);
        misal   = ((funct3 == 3'd1 || funct3 == 3'd5) && addr[0]) ||
                  (funct3 == 3'd2 && addr[1:0] != 2'b00);
        oor     = addr >= 32'(MEM_BYTES);
        code    = illegal ? 2'b11 : misal ? 2'b01 : oor ? 2'b10 : 2'b00;
    end

    always_comb begin
        rd_byte = mem_rdata[{off_q, 3'b000} +: 8];
        rd_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'd0:    load_val = {{24{rd_byte[7]}}, rd_byte};
            3'd1:    load_val = {{16{rd_half[15]}}, rd_half};
            3'd4:    load_val = {24'd0, rd_byte};
            3'd5:    load_val = {16'd0, rd_half};
            default: load_val = mem_rdata;
        endcase
        // Replicate the store lane across the word and let the mask pick the slot.
        if (f3_q == 3'd0) begin
            rmw_mask = 32'h0000_00ff << {off_q, 3'b000};
            rmw_data = {4{wdata_q[7:0]}};
        end else begin
            rmw_mask = off_q[1] ? 32'hffff_0000 : 32'h0000_ffff;
            rmw_data = {2{wdata_q[15:0]}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            f3_q     <= 3'd0;
            off_q    <= 2'd0;
            wdata_q  <= 32'd0;
            merged   <= 32'd0;
            mem_addr <= 32'd0;
            rdata    <= 32'd0;
            err      <= 1'b0;
            err_code <= 2'b00;
        end else begin
            case (state)
                IDLE: if (req) begin
                    we_q     <= we;
                    f3_q     <= funct3;
                    off_q    <= addr[1:0];
                    wdata_q  <= wdata;
                    mem_addr <= {addr[31:2], 2'b00};
                    err_code <= code;
                    err      <= (code != 2'b00);
                    if (code != 2'b00)
                        state <= DONE;
                    else if (we && funct3 == 3'd2) begin
                        merged <= wdata;
                        state  <= WR;
                    end else
                        state <= RD;
                end
                RD:  state <= USE;
                USE: begin
                    if (we_q) begin
                        merged <= (mem_rdata & ~rmw_mask) | (rmw_data & rmw_mask);
                        state  <= WR;
                    end else begin
                        rdata <= load_val;
                        state <= DONE;
                    end
                end
                WR:   state <= DONE;
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign ready     = (state == IDLE);
    assign done      = (state == DONE);
    assign mem_read  = (state == RD);
    assign mem_write = (state == WR);
    assign mem_wdata = (state == WR) ? merged : 32'd0;

endmodule
